// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single MCU data-memory port between the MCU
// core and the debug controller. Only one access is outstanding at a time.
// On a tie the requester that did not win last time wins. Byte accesses are
// turned into lane enables with replicated write data, and byte reads are
// extracted and zero-extended.
//
// Ports:
//   clk_i, reset_i      rising-edge clock, synchronous active-high reset
//   core_*_i / core_*_o core request/grant/read-return handshake
//   dbg_*_i  / dbg_*_o  debug level strobes, busy flag, last read result
//   mem_*_o / mem_rdata_i  memory port; read data valid RD_LAT cycles after mem_en
//
// All outputs are registered. Outputs that must be valid in the ISSUE cycle
// are computed on the IDLE->ISSUE transition.
module mem_port_arbiter #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic              core_byte_i,
    input  logic [31:0]       core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [DATA_W-1:0] core_rdata_o,

    input  logic              dbg_rd_i,
    input  logic              dbg_wr_i,
    input  logic              dbg_byte_i,
    input  logic [31:0]       dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_busy_o,
    output logic [DATA_W-1:0] dbg_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RD_WAIT,
        S_DBG_DONE
    } state_e;

    // Latched access of the current winner.
    typedef struct packed {
        logic              dbg;
        logic              we;
        logic              is_byte;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_e              state_q, state_d;
    req_t                req_q, req_d;
    req_t                win;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_dbg_q, last_dbg_d;

    logic                core_gnt_q, core_gnt_d;
    logic                core_rvalid_q, core_rvalid_d;
    logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
    logic                dbg_busy_q, dbg_busy_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                dbg_req;
    logic                pick_dbg;
    logic [7:0]          rd_byte;
    logic [DATA_W-1:0]   rd_val;

    // Arbitration: debug wins alone, or on a tie when the core won last.
    always_comb begin
        dbg_req  = dbg_rd_i | dbg_wr_i;
        pick_dbg = dbg_req & (~core_req_i | ~last_dbg_q);

        win.dbg = pick_dbg;
        if (pick_dbg) begin
            // Simultaneous rd and wr strobes are treated as a read.
            win.we      = dbg_wr_i & ~dbg_rd_i;
            win.is_byte = dbg_byte_i;
            win.addr    = dbg_addr_i;
            win.wdata   = dbg_wdata_i;
        end else begin
            win.we      = core_we_i;
            win.is_byte = core_byte_i;
            win.addr    = core_addr_i;
            win.wdata   = core_wdata_i;
        end
    end

    // Read data extraction: byte reads select the lane and zero-extend.
    always_comb begin
        rd_byte = mem_rdata_i[{req_q.addr[1:0], 3'b000} +: 8];
        if (req_q.is_byte) begin
            rd_val = {{(DATA_W-8){1'b0}}, rd_byte};
        end else begin
            rd_val = mem_rdata_i;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        cnt_d         = cnt_q;
        last_dbg_d    = last_dbg_q;
        core_gnt_d    = 1'b0;
        core_rvalid_d = 1'b0;
        core_rdata_d  = core_rdata_q;
        dbg_busy_d    = dbg_busy_q;
        dbg_rdata_d   = dbg_rdata_q;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_be_d      = '0;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (dbg_req | core_req_i) begin
                    req_d       = win;
                    state_d     = S_ISSUE;
                    // Memory strobe and grant appear in the ISSUE cycle.
                    mem_en_d    = 1'b1;
                    mem_we_d    = win.we;
                    mem_addr_d  = {win.addr[ADDR_W-1:2], 2'b00};
                    if (win.is_byte) begin
                        mem_be_d    = BE_W'(1) << win.addr[1:0];
                        mem_wdata_d = {BE_W{win.wdata[7:0]}};
                    end else begin
                        mem_be_d    = {BE_W{1'b1}};
                        mem_wdata_d = win.wdata;
                    end
                    core_gnt_d  = ~win.dbg;
                    dbg_busy_d  = win.dbg;
                end
            end

            S_ISSUE: begin
                last_dbg_d = req_q.dbg;
                if (req_q.we) begin
                    if (req_q.dbg) begin
                        state_d    = S_DBG_DONE;
                        dbg_busy_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_RD_WAIT;
                    cnt_d   = CNT_W'(RD_LAT);
                end
            end

            S_RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Count of 1 marks the cycle in which mem_rdata is valid.
                if (cnt_q == CNT_W'(1)) begin
                    if (req_q.dbg) begin
                        dbg_rdata_d = rd_val;
                        dbg_busy_d  = 1'b0;
                        state_d     = S_DBG_DONE;
                    end else begin
                        core_rdata_d  = rd_val;
                        core_rvalid_d = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
            end

            // One dead cycle so the still-held debug strobe is not re-sampled.
            S_DBG_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            req_q         <= '0;
            cnt_q         <= '0;
            last_dbg_q    <= 1'b0;
            core_gnt_q    <= 1'b0;
            core_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            dbg_busy_q    <= 1'b0;
            dbg_rdata_q   <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            cnt_q         <= cnt_d;
            last_dbg_q    <= last_dbg_d;
            core_gnt_q    <= core_gnt_d;
            core_rvalid_q <= core_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            dbg_busy_q    <= dbg_busy_d;
            dbg_rdata_q   <= dbg_rdata_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_be_q      <= mem_be_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign core_gnt_o    = core_gnt_q;
    assign core_rvalid_o = core_rvalid_q;
    assign core_rdata_o  = core_rdata_q;
    assign dbg_busy_o    = dbg_busy_q;
    assign dbg_rdata_o   = dbg_rdata_q;
    assign mem_en_o      = mem_en_q;
    assign mem_we_o      = mem_we_q;
    assign mem_be_o      = mem_be_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;

endmodule
